// File: rtl/ble_seq_pkg.sv
// Shared types and defaults for the BLE radio sequencer.
// State encoding is visible on seq_state, so IDLE must stay at 0.
package ble_seq_pkg;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int RAMP_CYCLES_DEFAULT = 4000;
  localparam int T_IFS_NOMINAL       = 15000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_RAMP   = 3'd1,
    ST_TX_ACTIVE = 3'd2,
    ST_IFS_WAIT  = 3'd3,
    ST_RX_RAMP   = 3'd4,
    ST_RX_LISTEN = 3'd5,
    ST_RX_BUSY   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/ble_seq_timer.sv
// Loadable down counter that saturates at zero; hold freezes it.
// The zero flag is decoded straight from the count register.
module ble_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses <=.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (!hold && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ble_radio_sequencer.sv
// TX/RX sequencer for the BLE PHY: radio ramp, T_IFS and RX listen window timing.
// Outputs are registered from the next state so they change together with seq_state.
module ble_radio_sequencer
  import ble_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int RAMP_CYCLES = RAMP_CYCLES_DEFAULT
) (
  input  logic             SYS_FCLK,
  input  logic             SYS_RESETn,
  input  logic             cmd_tx,
  input  logic             cmd_rx,
  input  logic             cmd_abort,
  input  logic             cfg_tx_then_rx,
  input  logic [CNT_W-1:0] cfg_ifs,
  input  logic [CNT_W-1:0] cfg_rx_win,
  input  logic             phy_tx_done,
  input  logic             phy_rx_sync,
  input  logic             phy_rx_done,
  output logic             phy_pa_en,
  output logic             phy_tx_en,
  output logic             phy_rx_en,
  output logic             busy,
  output logic [2:0]       seq_state,
  output logic             irq_tx_done,
  output logic             irq_rx_done,
  output logic             irq_rx_timeout,
  output logic             cmd_err
);

  localparam logic [CNT_W-1:0] RAMP_LOAD = CNT_W'(RAMP_CYCLES - 1);

  // A span of N cycles loads N-1; a programmed 0 behaves like 1.
  function automatic logic [CNT_W-1:0] span_load(input logic [CNT_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - 1'b1;
  endfunction

  seq_state_e       state_q, state_d;
  logic             load, hold, zero;
  logic [CNT_W-1:0] load_val;
  logic             tx_done_d, rx_done_d, rx_timeout_d, cmd_err_d;

  ble_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (SYS_FCLK),
    .rst_n    (SYS_RESETn),
    .load     (load),
    .load_val (load_val),
    .hold     (hold),
    .zero     (zero)
  );

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    state_d      = state_q;
    load         = 1'b0;
    load_val     = '0;
    hold         = 1'b0;
    tx_done_d    = 1'b0;
    rx_done_d    = 1'b0;
    rx_timeout_d = 1'b0;
    cmd_err_d    = 1'b0;

    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else begin
      cmd_err_d = (state_q != ST_IDLE) && (cmd_tx || cmd_rx);
      case (state_q)
        ST_IDLE: begin
          if (cmd_tx) begin
            state_d   = ST_TX_RAMP;
            load      = 1'b1;
            load_val  = RAMP_LOAD;
            cmd_err_d = cmd_rx;
          end else if (cmd_rx) begin
            state_d  = ST_RX_RAMP;
            load     = 1'b1;
            load_val = RAMP_LOAD;
          end
        end
        ST_TX_RAMP: if (zero) state_d = ST_TX_ACTIVE;
        ST_TX_ACTIVE: begin
          if (phy_tx_done) begin
            tx_done_d = 1'b1;
            if (cfg_tx_then_rx) begin
              state_d  = ST_IFS_WAIT;
              load     = 1'b1;
              load_val = span_load(cfg_ifs);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_IFS_WAIT, ST_RX_RAMP: begin
          if (zero) begin
            state_d  = ST_RX_LISTEN;
            load     = 1'b1;
            load_val = span_load(cfg_rx_win);
          end
        end
        ST_RX_LISTEN: begin
          // Sync beats a window expiring in the same cycle.
          if (phy_rx_sync) begin
            state_d = ST_RX_BUSY;
            hold    = 1'b1;
          end else if (zero) begin
            state_d      = ST_IDLE;
            rx_timeout_d = 1'b1;
          end
        end
        ST_RX_BUSY: begin
          hold = 1'b1;
          if (phy_rx_done) begin
            state_d   = ST_IDLE;
            rx_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Park the counter at 0 whenever the sequencer is idle.
    if (state_d == ST_IDLE) begin
      load     = 1'b1;
      load_val = '0;
    end
  end

  always_ff @(posedge SYS_FCLK) begin
    if (!SYS_RESETn) begin
      state_q        <= ST_IDLE;
      phy_pa_en      <= 1'b0;
      phy_tx_en      <= 1'b0;
      phy_rx_en      <= 1'b0;
      busy           <= 1'b0;
      irq_tx_done    <= 1'b0;
      irq_rx_done    <= 1'b0;
      irq_rx_timeout <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phy_pa_en      <= (state_d != ST_IDLE);
      phy_tx_en      <= (state_d == ST_TX_ACTIVE);
      phy_rx_en      <= (state_d == ST_RX_LISTEN) || (state_d == ST_RX_BUSY);
      busy           <= (state_d != ST_IDLE);
      irq_tx_done    <= tx_done_d;
      irq_rx_done    <= rx_done_d;
      irq_rx_timeout <= rx_timeout_d;
      cmd_err        <= cmd_err_d;
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_ble_radio_sequencer.sv
// Randomized bench: each sequence is planned as a timeline of phase boundaries,
// and every cycle's outputs are compared against that timeline.
module tb_ble_radio_sequencer;
  import ble_seq_pkg::*;

  localparam int CNT_W = 16;
  localparam int RAMP  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, cmd_tx, cmd_rx, cmd_abort, cfg_tx_then_rx;
  logic [CNT_W-1:0] cfg_ifs, cfg_rx_win;
  logic             phy_tx_done, phy_rx_sync, phy_rx_done;
  logic             phy_pa_en, phy_tx_en, phy_rx_en, busy;
  logic [2:0]       seq_state;
  logic             irq_tx_done, irq_rx_done, irq_rx_timeout, cmd_err;

  ble_radio_sequencer #(.CNT_W(CNT_W), .RAMP_CYCLES(RAMP)) dut (
    .SYS_FCLK       (clk),
    .SYS_RESETn     (rst_n),
    .cmd_tx         (cmd_tx),
    .cmd_rx         (cmd_rx),
    .cmd_abort      (cmd_abort),
    .cfg_tx_then_rx (cfg_tx_then_rx),
    .cfg_ifs        (cfg_ifs),
    .cfg_rx_win     (cfg_rx_win),
    .phy_tx_done    (phy_tx_done),
    .phy_rx_sync    (phy_rx_sync),
    .phy_rx_done    (phy_rx_done),
    .phy_pa_en      (phy_pa_en),
    .phy_tx_en      (phy_tx_en),
    .phy_rx_en      (phy_rx_en),
    .busy           (busy),
    .seq_state      (seq_state),
    .irq_tx_done    (irq_tx_done),
    .irq_rx_done    (irq_rx_done),
    .irq_rx_timeout (irq_rx_timeout),
    .cmd_err        (cmd_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {seq_state, phy_pa_en, phy_tx_en, phy_rx_en, busy,
            irq_tx_done, irq_rx_done, irq_rx_timeout, cmd_err};
  endfunction

  // Planned timeline; t=0 is the first cycle after the start command is sampled.
  bit sc_tx, sc_chain, sc_listen, sc_sync, sc_both;
  int sc_ifs, sc_win, sc_d, sc_s, sc_b;
  int t_tx_off, t_listen, t_busy, t_end;
  int t_err, err_kind, kill_at;
  bit kill_rst;

  task automatic plan(input bit is_tx, input bit chain, input int ifs, input int win,
                      input int d, input bit sync, input int s, input int b, input bit both);
    int span_ifs, span_win;
    sc_tx = is_tx; sc_chain = is_tx && chain; sc_listen = !is_tx || chain;
    sc_sync = sync; sc_both = is_tx && both;
    sc_ifs = ifs; sc_win = win; sc_d = d; sc_s = s; sc_b = b;
    span_ifs = (ifs == 0) ? 1 : ifs;
    span_win = (win == 0) ? 1 : win;
    t_tx_off = RAMP + d + 1;
    t_listen = is_tx ? t_tx_off + span_ifs : RAMP;
    t_busy   = 1 << 30;
    if (!sc_listen) t_end = t_tx_off;
    else if (sync) begin
      t_busy = t_listen + s + 1;
      t_end  = t_busy + b + 1;
    end else t_end = t_listen + span_win;
    t_err = -1; err_kind = 0; kill_at = -1; kill_rst = 0;
  endtask

  function automatic logic [10:0] expect_at(int t);
    seq_state_e st;
    logic itx, irx, ito, err;
    if (kill_at >= 0 && t > kill_at) return '0;
    if (t >= t_end)                      st = ST_IDLE;
    else if (t < RAMP)                   st = sc_tx ? ST_TX_RAMP : ST_RX_RAMP;
    else if (sc_tx && t < t_tx_off)      st = ST_TX_ACTIVE;
    else if (sc_tx && t < t_listen)      st = ST_IFS_WAIT;
    else if (sc_sync && t >= t_busy)     st = ST_RX_BUSY;
    else                                 st = ST_RX_LISTEN;
    itx = sc_tx && (t == t_tx_off);
    irx = sc_listen && sc_sync && (t == t_end);
    ito = sc_listen && !sc_sync && (t == t_end);
    err = (sc_both && t == 0) || (t_err >= 0 && t == t_err + 1);
    return {st, st != ST_IDLE, st == ST_TX_ACTIVE,
            (st == ST_RX_LISTEN) || (st == ST_RX_BUSY), st != ST_IDLE,
            itx, irx, ito, err};
  endfunction

  function automatic logic stray();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic drive(input int id);
    int t_last, span_win;
    span_win = (sc_win == 0) ? 1 : sc_win;
    cmd_tx = sc_tx; cmd_rx = !sc_tx || sc_both; cmd_abort = 0; rst_n = 1;
    cfg_tx_then_rx = sc_chain;
    cfg_ifs = CNT_W'($urandom); cfg_rx_win = CNT_W'($urandom);
    phy_tx_done = 0; phy_rx_sync = 0; phy_rx_done = 0;
    tick();
    t_last = (kill_at >= 0) ? kill_at + 3 : t_end;
    for (int t = 0; t <= t_last; t++) begin
      cmd_tx = 0; cmd_rx = 0; cmd_abort = 0; rst_n = 1;
      // cfg values hold their intended value only in the cycle they are loaded.
      cfg_ifs    = (sc_chain && t == t_tx_off - 1) ? CNT_W'(sc_ifs) : CNT_W'($urandom);
      cfg_rx_win = (sc_listen && t == t_listen - 1) ? CNT_W'(sc_win) : CNT_W'($urandom);
      if (sc_tx && t >= RAMP && t <= RAMP + sc_d) phy_tx_done = (t == RAMP + sc_d);
      else phy_tx_done = stray();
      if (sc_listen && t >= t_listen && t <= t_listen + (sc_sync ? sc_s : span_win - 1))
        phy_rx_sync = sc_sync && (t == t_listen + sc_s);
      else phy_rx_sync = stray();
      if (sc_listen && sc_sync && t >= t_busy && t <= t_busy + sc_b)
        phy_rx_done = (t == t_busy + sc_b);
      else phy_rx_done = stray();
      if (t == t_err) begin
        cmd_tx = err_kind[0];
        cmd_rx = err_kind[1];
      end
      if (t == kill_at) begin
        if (kill_rst) rst_n = 0;
        else cmd_abort = 1;
      end
      check($sformatf("seq%0d t=%0d", id, t), 32'(obs()), 32'(expect_at(t)));
      tick();
    end
    cmd_tx = 0; cmd_rx = 0; rst_n = 1;
    phy_tx_done = 0; phy_rx_sync = 0; phy_rx_done = 0;
    cmd_abort = 1;
    tick();
    cmd_abort = 0;
    check($sformatf("seq%0d idle after abort", id), 32'(obs()), 32'd0);
  endtask

  initial begin
    int id, hi;
    bit is_tx, sync;
    int win, span;
    rst_n = 0; cmd_tx = 0; cmd_rx = 0; cmd_abort = 0; cfg_tx_then_rx = 0;
    cfg_ifs = '0; cfg_rx_win = '0;
    phy_tx_done = 0; phy_rx_sync = 0; phy_rx_done = 0;
    tick();
    check("reset first edge", 32'(obs()), 32'd0);
    cmd_tx = 1;
    tick();
    check("cmd during reset", 32'(obs()), 32'd0);
    cmd_tx = 0; rst_n = 1;
    tick();
    check("idle after reset", 32'(obs()), 32'd0);

    id = 0;
    plan(1, 0, 0, 0, 20, 0, 0, 0, 0);        drive(id++); // TX only
    plan(1, 1, 150, 50, 5, 1, 10, 30, 0);    drive(id++); // TX then RX with sync
    plan(0, 0, 0, 50, 0, 0, 0, 0, 0);        drive(id++); // RX timeout
    plan(0, 0, 0, 20, 0, 1, 19, 3, 0);       drive(id++); // sync on expiry cycle
    plan(1, 0, 0, 0, 3, 0, 0, 0, 1);         drive(id++); // simultaneous commands
    plan(1, 0, 0, 0, 10, 0, 0, 0, 0);
    t_err = RAMP + 2; err_kind = 2;          drive(id++); // cmd_rx during TX_ACTIVE
    plan(1, 1, 10, 30, 4, 1, 5, 20, 0);
    kill_at = t_tx_off + 2;                  drive(id++); // abort in IFS_WAIT
    plan(1, 1, 10, 30, 4, 1, 5, 20, 0);
    kill_at = t_busy + 4; kill_rst = 1;      drive(id++); // reset in RX_BUSY
    plan(1, 1, 0, 0, 0, 0, 0, 0, 0);         drive(id++); // zero cfg spans

    repeat (40) begin
      is_tx = 1'($urandom_range(0, 1));
      sync  = 1'($urandom_range(0, 1));
      win   = $urandom_range(0, 30);
      span  = (win == 0) ? 1 : win;
      plan(is_tx, 1'($urandom_range(0, 1)), $urandom_range(0, 40), win,
           $urandom_range(0, 15), sync, $urandom_range(0, span - 1),
           $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        kill_at  = $urandom_range(0, t_end - 1);
        kill_rst = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 2) == 0) begin
        hi = t_end - 1;
        if (kill_at >= 0 && kill_at < hi) hi = kill_at;
        t_err    = $urandom_range(0, hi);
        err_kind = $urandom_range(1, 3);
      end
      drive(id++);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
